// File: rtl/bcd_display_scanner_if.sv
// Display-side bundle for the two-digit BCD scanner: packed BCD value and hold in,
// multiplexed segment/anode drive and error flag out.
interface bcd_display_scanner_if;
  logic [7:0] count;
  logic       hold;
  logic [6:0] seg;
  logic [1:0] an;
  logic       err;

  modport master (output count, output hold, input seg, input an, input err);
  modport slave  (input count, input hold, output seg, output an, output err);
endinterface

// File: rtl/bcd_display_scanner.sv
// Two-digit multiplexed 7-segment scanner: ones/gap/tens/gap frame, value latched
// into a shadow register once per frame so a digit never tears mid-frame.
module bcd_display_scanner #(
  parameter int unsigned REFRESH_DIV = 4,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  bcd_display_scanner_if.slave  bus
);

  localparam int unsigned DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {
    ST_ONES = 2'd0,
    ST_GAP0 = 2'd1,
    ST_TENS = 2'd2,
    ST_GAP1 = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [7:0]    shadow_q, shadow_d;
  logic          dwell_last;

  // Active-high a..g pattern; anything above 9 shows "E".
  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h79;
    endcase
  endfunction

  assign dwell_last = (dwell_q == DW'(REFRESH_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_ONES;
      dwell_q  <= '0;
      shadow_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      shadow_q <= shadow_d;
    end
  end

  // Next state plus Moore decode of the digit drive from state and shadow.
  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q;
    shadow_d = shadow_q;
    bus.an   = 2'b00;
    bus.seg  = 7'h00;
    case (state_q)
      ST_ONES: begin
        bus.an  = 2'b01;
        bus.seg = decode(shadow_q[3:0]);
        if (dwell_last) begin
          dwell_d = '0;
          state_d = ST_GAP0;
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      ST_GAP0: state_d = ST_TENS;
      ST_TENS: begin
        if (!(BLANK_LZ && (shadow_q[7:4] == 4'd0))) begin
          bus.an  = 2'b10;
          bus.seg = decode(shadow_q[7:4]);
        end
        if (dwell_last) begin
          dwell_d = '0;
          state_d = ST_GAP1;
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      ST_GAP1: begin
        state_d = ST_ONES;
        if (!bus.hold) shadow_d = bus.count;
      end
      default: state_d = ST_ONES;
    endcase
  end

  assign bus.err = (shadow_q[7:4] > 4'd9) || (shadow_q[3:0] > 4'd9);

endmodule
